// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder.
// The requester drives the operands and the start strobe; the adder
// answers with busy/done and the registered sum and carry-out.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] z;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, z, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, z, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full adder processes the operands LSB first,
// one bit per clock. An operation is accepted from IDLE or DONE, runs
// for WIDTH cycles in RUN, then presents {cout, z} with a one-cycle done.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  // The counter must be able to hold WIDTH so it never wraps mid-operation.
  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             sum_bit;
  logic             carry_bit;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] sum_word;

  // Single full adder on the current LSBs and the running carry.
  assign sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_bit = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  // A request is taken whenever no addition is in flight, so start held
  // through DONE chains operations back to back.
  assign accept   = bus.start && (state_q != RUN);
  assign last_bit = (cnt_q == LAST_BIT);

  // Partial-result shift register. It holds the WIDTH-1 sum bits produced
  // so far; sum_word prepends the bit being produced this cycle, which on
  // the final bit is the complete result. WIDTH=1 needs no storage at all.
  generate
    if (WIDTH == 1) begin : g_res_single
      assign sum_word = sum_bit;
    end else begin : g_res_multi
      logic [WIDTH-2:0] res_q, res_d;

      assign sum_word = {sum_bit, res_q};

      // New sum bits enter at the MSB end and older bits move down.
      always_comb begin
        res_d = res_q;
        if (accept) begin
          res_d = '0;
        end else if (state_q == RUN) begin
          res_d = sum_word[WIDTH-1:1];
        end
      end

      // Partial-result register, cleared by reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_q <= '0;
        end else begin
          res_q <= res_d;
        end
      end
    end
  endgenerate

  // Next-state logic: RUN lasts exactly WIDTH cycles, DONE exactly one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = bus.start ? RUN : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: load on acceptance, shift one bit per RUN cycle, and publish
  // the result only on the final bit so z/cout hold between completions.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    cout_d  = cout_q;
    if (accept) begin
      a_d     = bus.a;
      b_d     = bus.b;
      carry_d = bus.cin;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      carry_d = carry_bit;
      cnt_d   = cnt_q + CNT_W'(1);
      if (last_bit) begin
        z_d    = sum_word;
        cout_d = carry_bit;
      end
    end
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      z_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.z    = z_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference behaviour: an accepted request produces a+b+cin exactly W
  // clock edges later; requests are taken only when nothing is pending.
  int         left8;
  logic [8:0] pend8, res8;
  logic       done8_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left8   <= 0;
      pend8   <= '0;
      res8    <= '0;
      done8_e <= 1'b0;
    end else begin
      done8_e <= 1'b0;
      if (left8 > 0) begin
        left8 <= left8 - 1;
        if (left8 == 1) begin
          res8    <= pend8;
          done8_e <= 1'b1;
        end
      end else if (bus8.start) begin
        left8 <= 8;
        pend8 <= {1'b0, bus8.a} + {1'b0, bus8.b} + {8'b0, bus8.cin};
      end
    end
  end

  int         left1;
  logic [1:0] pend1, res1;
  logic       done1_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left1   <= 0;
      pend1   <= '0;
      res1    <= '0;
      done1_e <= 1'b0;
    end else begin
      done1_e <= 1'b0;
      if (left1 > 0) begin
        left1 <= left1 - 1;
        if (left1 == 1) begin
          res1    <= pend1;
          done1_e <= 1'b1;
        end
      end else if (bus1.start) begin
        left1 <= 1;
        pend1 <= {1'b0, bus1.a} + {1'b0, bus1.b} + {1'b0, bus1.cin};
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic compareCycle();
    logic [10:0] got8, exp8;
    logic [3:0]  got1, exp1;
    got8 = {bus8.busy, bus8.done, bus8.z, bus8.cout};
    exp8 = {(left8 > 0), done8_e, res8[7:0], res8[8]};
    got1 = {bus1.busy, bus1.done, bus1.z, bus1.cout};
    exp1 = {(left1 > 0), done1_e, res1[0], res1[1]};
    checkOutput("cycle w8 {busy,done,z,cout}", 32'(got8), 32'(exp8));
    checkOutput("cycle w1 {busy,done,z,cout}", 32'(got1), 32'(exp1));
  endtask

  // Called at a negedge with the DUT idle or in DONE.
  task automatic applyStimulus(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                               input bit changeAfter, input bit restartMid, input string tag,
                               input logic [7:0] expZ, input logic expCout);
    int busyCount;
    int latency;
    bit seen;
    bus8.start = 1'b1;
    bus8.a     = ai;
    bus8.b     = bi;
    bus8.cin   = ci;
    @(posedge clk);
    #1 bus8.start = 1'b0;
    if (changeAfter) begin
      bus8.a   = 8'hFF;
      bus8.b   = 8'hFF;
      bus8.cin = ~ci;
    end
    busyCount = 0;
    latency   = -1;
    seen      = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (restartMid && i == 3) begin
        bus8.start = 1'b1;
        bus8.a     = 8'h77;
        bus8.b     = 8'h66;
      end
      if (restartMid && i == 4) bus8.start = 1'b0;
      if (bus8.busy) busyCount++;
      if (bus8.done) begin
        seen    = 1'b1;
        latency = i - 1;
      end
    end
    checkOutput({tag, " done latency"}, latency, 8);
    checkOutput({tag, " busy cycles"}, busyCount, 8);
    checkOutput({tag, " z"}, 32'(bus8.z), 32'(expZ));
    checkOutput({tag, " cout"}, 32'(bus8.cout), 32'(expCout));
  endtask

  task automatic runWidth1(input logic [2:0] v);
    int doneCount;
    int busyCount;
    int s;
    logic zSeen, coutSeen;
    s = int'(v[2]) + int'(v[1]) + int'(v[0]);
    bus1.start = 1'b1;
    bus1.a     = v[2];
    bus1.b     = v[1];
    bus1.cin   = v[0];
    @(posedge clk);
    #1 bus1.start = 1'b0;
    doneCount = 0;
    busyCount = 0;
    zSeen     = 1'b0;
    coutSeen  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (bus1.busy) busyCount++;
      if (bus1.done) begin
        doneCount++;
        zSeen    = bus1.z;
        coutSeen = bus1.cout;
      end
    end
    checkOutput($sformatf("w1 abc=%0d done count", v), doneCount, 1);
    checkOutput($sformatf("w1 abc=%0d busy cycles", v), busyCount, 1);
    checkOutput($sformatf("w1 abc=%0d z", v), 32'(zSeen), s % 2);
    checkOutput($sformatf("w1 abc=%0d cout", v), 32'(coutSeen), s / 2);
  endtask

  initial begin
    int d1, d2, doneCount;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;

    fork
      forever begin
        @(negedge clk);
        compareCycle();
      end
    join_none

    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(bus8.busy), 0);
    checkOutput("reset done", 32'(bus8.done), 0);
    checkOutput("reset z", 32'(bus8.z), 0);
    checkOutput("reset cout", 32'(bus8.cout), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Carry ripples through every bit.
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, "ff+01", 8'h00, 1'b1);
    checkOutput("model pin ff+01", 32'(res8), 32'h100);

    // Alternating bits with carry-in, then a plain sum; z/cout must hold.
    applyStimulus(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0, "a5+5a+1", 8'h00, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("hold z", 32'(bus8.z), 32'h00);
    checkOutput("hold cout", 32'(bus8.cout), 1);
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, "12+34", 8'h46, 1'b0);
    repeat (2) @(negedge clk);

    // Operands change after acceptance; start re-pulsed mid-run.
    applyStimulus(8'h00, 8'h0F, 1'b1, 1'b1, 1'b0, "late operand change", 8'h10, 1'b0);
    repeat (2) @(negedge clk);
    applyStimulus(8'h30, 8'h0C, 1'b0, 1'b0, 1'b1, "restart mid-run", 8'h3C, 1'b0);
    repeat (2) @(negedge clk);

    // Start held high through DONE chains operations every WIDTH+1 cycles.
    bus8.start = 1'b1; bus8.a = 8'h11; bus8.b = 8'h22; bus8.cin = 1'b0;
    d1 = -1;
    d2 = -1;
    for (int i = 1; i <= 40 && d2 < 0; i++) begin
      @(negedge clk);
      if (bus8.done) begin
        if (d1 < 0) d1 = i;
        else begin
          d2 = i;
          bus8.start = 1'b0;
        end
      end
    end
    bus8.start = 1'b0;
    checkOutput("back-to-back period", d2 - d1, 9);
    checkOutput("back-to-back z", 32'(bus8.z), 32'h33);
    repeat (2) @(negedge clk);

    // Reset while bit 4 is next to be processed.
    bus8.start = 1'b1; bus8.a = 8'h5A; bus8.b = 8'h0F; bus8.cin = 1'b0;
    @(posedge clk);
    #1 bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid-run reset busy", 32'(bus8.busy), 0);
    checkOutput("mid-run reset done", 32'(bus8.done), 0);
    checkOutput("mid-run reset z", 32'(bus8.z), 0);
    checkOutput("mid-run reset cout", 32'(bus8.cout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus8.done) doneCount++;
    end
    checkOutput("no done after abort", doneCount, 0);
    applyStimulus(8'hC8, 8'h64, 1'b1, 1'b0, 1'b0, "after reset c8+64+1", 8'h2D, 1'b1);
    repeat (2) @(negedge clk);

    // WIDTH=1: full-adder truth table.
    for (int v = 0; v < 8; v++) begin
      runWidth1(3'(v));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand width in bits (legal 1..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request to add the a, b, cin values sampled on the same edge.
REQ-005 SHALL have port: a  input  WIDTH  operand A.
REQ-006 SHALL have port: b  input  WIDTH  operand B.
REQ-007 SHALL have port: cin  input  1  carry-in to bit 0.
REQ-008 SHALL have port: busy  output  1  high while an addition is in progress.
REQ-009 SHALL have port: done  output  1  one-cycle pulse; z and cout are valid.
REQ-010 SHALL have port: z  output  WIDTH  registered sum.
REQ-011 SHALL have port: cout  output  1  registered carry-out of bit WIDTH-1.

Function
REQ-012 SHALL use a single 1-bit full-adder datapath: sum = a_bit^b_bit^c; carry = majority(a_bit, b_bit, c).
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 IDLE: on a rising edge with start=1, SHALL load a and b into internal shift registers, load cin into the carry register, clear the bit counter and enter RUN.
REQ-015 RUN: each edge SHALL process one bit, LSB first: shift the sum bit into the result shift register at the MSB end, update the carry, shift the operands right and increment the counter.
REQ-016 RUN: on the edge that processes bit WIDTH-1, SHALL copy the full result to z, copy the final carry to cout, and enter DONE.
REQ-017 DONE: SHALL assert done for exactly one cycle and SHALL then return to IDLE; if start=1 in DONE, SHALL accept it as in IDLE and enter RUN directly.
REQ-018 Latency: if start is sampled at edge k, done SHALL be high in the cycle following edge k+WIDTH; throughput is one addition per WIDTH+1 cycles.
REQ-019 busy SHALL be high exactly in RUN.
REQ-020 start SHALL be ignored while in RUN; a, b and cin SHALL be sampled only on the accepting edge, and later input changes SHALL NOT affect the result.
REQ-021 z and cout SHALL change only on the completing edge of REQ-016 and SHALL hold their value until the next completion.
REQ-022 {cout, z} SHALL equal a + b + cin computed to WIDTH+1 bits, with no truncation or saturation.
REQ-023 WIDTH=1: RUN SHALL last one cycle, and the result SHALL be a full-adder truth-table output.
REQ-024 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, z=0, cout=0, and clear the carry, counter and shift registers, independent of clk.
REQ-026 A reset during RUN SHALL abort the operation with no done pulse and no change to z or cout other than clearing them.
REQ-027 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-028 WIDTH=8, a=8'hFF, b=8'h01, cin=0, start pulsed -> busy high for 8 cycles, done 8 edges after the start edge, z=8'h00, cout=1.
REQ-029 WIDTH=8, a=8'hA5, b=8'h5A, cin=1 -> z=8'h00, cout=1; then a=8'h12, b=8'h34, cin=0 -> z=8'h46, cout=0, with z and cout held between done pulses.
REQ-030 WIDTH=1, exhaustive loop over all 8 (a, b, cin) combinations -> every result z = a^b^cin and cout = majority, one done per operation.
REQ-031 start re-pulsed mid-RUN with different operands -> ignored, first result unchanged; start held high through DONE -> back-to-back operations with a WIDTH+1 cycle period.
REQ-032 rst_n pulsed low at RUN bit 4 -> busy, done, z and cout immediately 0 and no done pulse; the next start gives a correct result.
REQ-033 Operands changed during RUN (a=8'h00 to 8'hFF after acceptance) -> result reflects the sampled operands only.
